// File: rtl/exp16_arb_pkg.sv
// Shared definitions for the exp16 share arbiter.
//   H_ZERO / H_ONE : FP16 constants
//   tag_w()        : width of a requester tag for a given requester count
//   rr_first()     : round-robin first-set search (up to RR_MAX requesters)
package exp16_arb_pkg;

    localparam logic [15:0] H_ZERO = 16'h0000;
    localparam logic [15:0] H_ONE  = 16'h3C00;

    localparam int unsigned RR_MAX = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    function automatic int unsigned tag_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of valid at or after ptr, wrapping within n entries.
    function automatic rr_pick_t rr_first(input logic [RR_MAX-1:0] valid,
                                          input logic [2:0]        ptr,
                                          input int unsigned       n);
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= n) cand = cand - n;
            if (k < n && !pick.found && valid[cand[2:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/exp16_arb_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight operand.
// Ports:
//   clk, rstn         clock, async active-low reset
//   push, push_data   write a tag (ignored when full)
//   pop, pop_data     read head tag (pop ignored when empty); pop_data is the head
//   count/full/empty  occupancy; push and pop may occur in the same cycle
module exp16_arb_tag_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        full     = (count == (AW+1)'(DEPTH));
        empty    = (count == '0);
        pop_data = mem[rd_ptr];
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/exp16_share_arb.sv
// Shares one pipelined FP16 e^x unit between N_REQ requesters.
// Round-robin issue of one operand per cycle; an in-order tag FIFO routes
// each result back to the requester that issued it.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   en_i                           arbitration enable (in-flight results still drain)
//   req_valid_i/req_x_i/req_ready_o requester operand handshake (one-hot grant)
//   exp_valid_o/exp_x_o            operand to exp unit (registered)
//   exp_valid_i/exp_y_i            result from exp unit
//   rsp_valid_o/rsp_y_o            one-hot result strobe and shared result (registered)
//   inflight_o/busy_o              operands issued but not yet returned
//   err_o                          sticky: result seen with no tag outstanding
// Optional feature macro EXP16_ARB_STATS_EN adds stat_clr_i / stat_grant_o
// (per-requester saturating 32-bit grant counters).
module exp16_share_arb
    import exp16_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DW           = 16,
    parameter int unsigned MAX_INFLIGHT = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            en_i,
    input  logic [N_REQ-1:0]                req_valid_i,
    input  logic [N_REQ*DW-1:0]             req_x_i,
    output logic [N_REQ-1:0]                req_ready_o,
    output logic                            exp_valid_o,
    output logic [DW-1:0]                   exp_x_o,
    input  logic                            exp_valid_i,
    input  logic [DW-1:0]                   exp_y_i,
    output logic [N_REQ-1:0]                rsp_valid_o,
    output logic [DW-1:0]                   rsp_y_o,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight_o,
    output logic                            busy_o,
    output logic                            err_o
`ifdef EXP16_ARB_STATS_EN
   ,input  logic                            stat_clr_i,
    output logic [N_REQ*32-1:0]             stat_grant_o
`endif
);
    localparam int unsigned TW = tag_w(N_REQ);

    logic [RR_MAX-1:0]           valid_ext;
    logic [2:0]                  rr_ptr;
    rr_pick_t                    pick;
    logic                        grant;
    logic [DW-1:0]               sel_x;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic [TW-1:0]               pop_tag;
    logic [N_REQ-1:0]            rsp_next;
    logic [$clog2(MAX_INFLIGHT):0] fifo_count;

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = req_valid_i;
        pick                   = rr_first(valid_ext, rr_ptr, N_REQ);
        // rstn gating keeps the combinational grant at 0 while reset is held.
        grant                  = rstn && en_i && pick.found && !fifo_full;
        req_ready_o            = '0;
        sel_x                  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick.idx == 3'(i)) begin
                req_ready_o[i] = grant;
                sel_x          = req_x_i[i*DW +: DW];
            end
        end
        pop      = exp_valid_i && !fifo_empty;
        rsp_next = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_next[i] = pop && (pop_tag == TW'(i));
        end
        inflight_o = fifo_count;
        busy_o     = (fifo_count != '0);
    end

    exp16_arb_tag_fifo #(
        .W     (TW),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (grant),
        .push_data (pick.idx[TW-1:0]),
        .pop       (pop),
        .pop_data  (pop_tag),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr      <= '0;
            exp_valid_o <= 1'b0;
            exp_x_o     <= DW'(H_ZERO);
            rsp_valid_o <= '0;
            rsp_y_o     <= DW'(H_ZERO);
            err_o       <= 1'b0;
        end else begin
            exp_valid_o <= grant;
            if (grant) begin
                exp_x_o <= sel_x;
                rr_ptr  <= (pick.idx == 3'(N_REQ-1)) ? 3'd0 : pick.idx + 3'd1;
            end
            rsp_valid_o <= rsp_next;
            if (pop) rsp_y_o <= exp_y_i;
            if (exp_valid_i && fifo_empty) err_o <= 1'b1;
        end
    end

`ifdef EXP16_ARB_STATS_EN
    logic [31:0] grant_cnt [N_REQ];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (stat_clr_i)
                    grant_cnt[i] <= '0;
                else if (req_ready_o[i] && grant_cnt[i] != '1)
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_grant_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) stat_grant_o[i*32 +: 32] = grant_cnt[i];
    end
`endif

endmodule
